// File: rtl/packet_capture_pkg.sv
// packet_capture_pkg: shared FSM encodings and helper functions for the
// packet_capture datapath blocks.
package packet_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FWD     = 2'd1,
        ST_DISCARD = 2'd2
    } ingress_state_e;

    // Occupancy above which a FIFO can no longer absorb a whole max-size packet.
    function automatic int admit_threshold(input int depth_bits, input int max_pkt_beats);
        return (32'sd1 << depth_bits) - max_pkt_beats;
    endfunction

    // 32-bit counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        logic [31:0] result;
        if (value == 32'hFFFF_FFFF) begin
            result = value;
        end else begin
            result = value + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: small first-word-fall-through FIFO. A word written on
// one edge is presented on dout right after that edge; prog_full flags an
// occupancy strictly above PROG_FULL_THRESHOLD.
module fallthrough_small_fifo #(
    parameter int WIDTH               = 72,
    parameter int MAX_DEPTH_BITS      = 3,
    parameter int PROG_FULL_THRESHOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             prog_full,
    output logic             empty
);

    localparam int DEPTH = 32'sd1 << MAX_DEPTH_BITS;
    localparam int CNT_W = MAX_DEPTH_BITS + 1;
    localparam logic [CNT_W-1:0]          DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]          THRESH_C = CNT_W'(PROG_FULL_THRESHOLD);
    localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(32'd1);
    localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE  = MAX_DEPTH_BITS'(32'd1);

    logic [WIDTH-1:0]          mem_r [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_r;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_r;
    logic [CNT_W-1:0]          count_r;
    logic                      push_s;
    logic                      pop_s;

    assign push_s    = wr_en & ~full;
    assign pop_s     = rd_en & ~empty;
    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign prog_full = (count_r > THRESH_C);
    assign dout      = mem_r[rd_ptr_r];

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {MAX_DEPTH_BITS{1'b0}};
            rd_ptr_r <= {MAX_DEPTH_BITS{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/replicator_out_channel.sv
// replicator_out_channel: one output leg of the packet replicator. Holds the
// per-output FIFO, rewrites the destination field on first beats and keeps the
// admitted / dropped packet counters for this output.
module replicator_out_channel
    import packet_capture_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int FIFO_DEPTH_BITS    = 7,
    parameter int MAX_PKT_BEATS      = 50,
    parameter int DST_LSB            = 24,
    parameter int DST_WIDTH          = 8
) (
    input  logic                              axi_aclk,
    input  logic                              axi_aresetn,
    input  logic                              wr_en,
    input  logic                              wr_first,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      wr_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    wr_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     wr_tuser,
    input  logic                              wr_tlast,
    input  logic [DST_WIDTH-1:0]              dst_port,
    input  logic                              drop_inc,
    output logic [C_AXIS_DATA_WIDTH-1:0]      m_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_tuser,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic                              m_tlast,
    output logic                              space_low,
    output logic                              full,
    output logic [31:0]                       pkt_count,
    output logic [31:0]                       drop_count
);

    localparam int FIFO_W = C_AXIS_DATA_WIDTH + C_AXIS_DATA_WIDTH/8 + C_AXIS_TUSER_WIDTH + 1;

    logic [C_AXIS_TUSER_WIDTH-1:0] tuser_s;
    logic [FIFO_W-1:0]             fifo_din_s;
    logic [FIFO_W-1:0]             fifo_dout_s;
    logic                          empty_s;
    logic [31:0]                   pkt_count_r;
    logic [31:0]                   drop_count_r;

    // Destination-field rewrite; only the first beat of a copy is modified.
    always_comb begin
        tuser_s = wr_tuser;
        if (wr_first) begin
            tuser_s[DST_LSB +: DST_WIDTH] = dst_port;
        end else begin
            tuser_s = wr_tuser;
        end
    end

    assign fifo_din_s = {wr_tlast, tuser_s, wr_tstrb, wr_tdata};

    fallthrough_small_fifo #(
        .WIDTH               (FIFO_W),
        .MAX_DEPTH_BITS      (FIFO_DEPTH_BITS),
        .PROG_FULL_THRESHOLD (admit_threshold(FIFO_DEPTH_BITS, MAX_PKT_BEATS))
    ) u_fifo (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .din       (fifo_din_s),
        .wr_en     (wr_en),
        .rd_en     (m_tready),
        .dout      (fifo_dout_s),
        .full      (full),
        .prog_full (space_low),
        .empty     (empty_s)
    );

    assign {m_tlast, m_tuser, m_tstrb, m_tdata} = fifo_dout_s;
    assign m_tvalid = ~empty_s;

    // Saturating admitted-packet and dropped-copy counters for this output.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pkt_count_r  <= 32'd0;
            drop_count_r <= 32'd0;
        end else begin
            if (wr_en && wr_first) begin
                pkt_count_r <= sat_inc32(pkt_count_r);
            end
            if (drop_inc) begin
                drop_count_r <= sat_inc32(drop_count_r);
            end
        end
    end

    assign pkt_count  = pkt_count_r;
    assign drop_count = drop_count_r;

endmodule

// File: rtl/packet_replicator.sv
// packet_replicator: copies each input packet to a selectable set of output
// ports. Admission is decided per output on the first beat and held for the
// whole packet; each output drains independently through its own FIFO.
module packet_replicator
    import packet_capture_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_OUTPUTS        = 2,
    parameter int FIFO_DEPTH_BITS    = 7,
    parameter int MAX_PKT_BEATS      = 50,
    parameter int DST_LSB            = 24,
    parameter int DST_WIDTH          = 8
) (
    input  logic                                          axi_aclk,
    input  logic                                          axi_aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]                  s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]                s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]                 s_axis_tuser,
    input  logic                                          s_axis_tvalid,
    output logic                                          s_axis_tready,
    input  logic                                          s_axis_tlast,
    output logic [NUM_OUTPUTS*C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [NUM_OUTPUTS*(C_AXIS_DATA_WIDTH/8)-1:0]  m_axis_tstrb,
    output logic [NUM_OUTPUTS*C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic [NUM_OUTPUTS-1:0]                        m_axis_tvalid,
    input  logic [NUM_OUTPUTS-1:0]                        m_axis_tready,
    output logic [NUM_OUTPUTS-1:0]                        m_axis_tlast,
    input  logic [NUM_OUTPUTS-1:0]                        out_enable,
    input  logic [NUM_OUTPUTS*DST_WIDTH-1:0]              dst_ports,
    output logic [NUM_OUTPUTS*32-1:0]                     pkt_count,
    output logic [NUM_OUTPUTS*32-1:0]                     drop_count
);

    localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

    ingress_state_e         state_r;
    ingress_state_e         state_nxt_s;
    logic [NUM_OUTPUTS-1:0] mask_r;
    logic [NUM_OUTPUTS-1:0] admit_s;
    logic [NUM_OUTPUTS-1:0] wr_mask_s;
    logic [NUM_OUTPUTS-1:0] drop_mask_s;
    logic [NUM_OUTPUTS-1:0] space_low_s;
    logic [NUM_OUTPUTS-1:0] full_s;
    logic                   live_r;
    logic                   ready_s;
    logic                   first_s;
    logic                   accept_s;

    // Candidate mask for a first beat: enabled outputs that can hold a whole packet.
    assign admit_s       = out_enable & ~space_low_s;
    assign accept_s      = s_axis_tvalid & ready_s;
    assign s_axis_tready = ready_s;

    // State register, admit-mask latch and out-of-reset flag.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_r <= ST_IDLE;
            mask_r  <= {NUM_OUTPUTS{1'b0}};
            live_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            live_r  <= 1'b1;
            if ((state_r == ST_IDLE) && accept_s) begin
                mask_r <= admit_s;
            end
        end
    end

    // Next-state logic: a first beat chooses FWD or DISCARD unless it also ends the packet.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !s_axis_tlast) begin
                    if (|admit_s) begin
                        state_nxt_s = ST_FWD;
                    end else begin
                        state_nxt_s = ST_DISCARD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FWD, ST_DISCARD: begin
                if (accept_s && s_axis_tlast) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: input ready, per-output write strobes and drop strobes.
    always_comb begin
        ready_s     = 1'b0;
        first_s     = 1'b0;
        wr_mask_s   = {NUM_OUTPUTS{1'b0}};
        drop_mask_s = {NUM_OUTPUTS{1'b0}};
        case (state_r)
            ST_IDLE: begin
                first_s = 1'b1;
                ready_s = live_r & ~|(admit_s & full_s);
                if (s_axis_tvalid && ready_s) begin
                    wr_mask_s   = admit_s;
                    drop_mask_s = out_enable & ~admit_s;
                end else begin
                    wr_mask_s   = {NUM_OUTPUTS{1'b0}};
                    drop_mask_s = {NUM_OUTPUTS{1'b0}};
                end
            end
            ST_FWD: begin
                ready_s = live_r & ~|(mask_r & full_s);
                if (s_axis_tvalid && ready_s) begin
                    wr_mask_s = mask_r;
                end else begin
                    wr_mask_s = {NUM_OUTPUTS{1'b0}};
                end
            end
            ST_DISCARD: begin
                ready_s = live_r;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
        replicator_out_channel #(
            .C_AXIS_DATA_WIDTH  (C_AXIS_DATA_WIDTH),
            .C_AXIS_TUSER_WIDTH (C_AXIS_TUSER_WIDTH),
            .FIFO_DEPTH_BITS    (FIFO_DEPTH_BITS),
            .MAX_PKT_BEATS      (MAX_PKT_BEATS),
            .DST_LSB            (DST_LSB),
            .DST_WIDTH          (DST_WIDTH)
        ) u_chan (
            .axi_aclk    (axi_aclk),
            .axi_aresetn (axi_aresetn),
            .wr_en       (wr_mask_s[i]),
            .wr_first    (first_s),
            .wr_tdata    (s_axis_tdata),
            .wr_tstrb    (s_axis_tstrb),
            .wr_tuser    (s_axis_tuser),
            .wr_tlast    (s_axis_tlast),
            .dst_port    (dst_ports[i*DST_WIDTH +: DST_WIDTH]),
            .drop_inc    (drop_mask_s[i]),
            .m_tdata     (m_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH]),
            .m_tstrb     (m_axis_tstrb[i*STRB_W +: STRB_W]),
            .m_tuser     (m_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH]),
            .m_tvalid    (m_axis_tvalid[i]),
            .m_tready    (m_axis_tready[i]),
            .m_tlast     (m_axis_tlast[i]),
            .space_low   (space_low_s[i]),
            .full        (full_s[i]),
            .pkt_count   (pkt_count[i*32 +: 32]),
            .drop_count  (drop_count[i*32 +: 32])
        );
    end

endmodule

// File: tb/tb_packet_replicator.sv
// tb_packet_replicator: directed, table-driven bench for packet_replicator
// with two outputs, plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_packet_replicator;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int SW = DW / 8;

    logic            axi_aclk = 1'b0;
    logic            axi_aresetn;
    logic [DW-1:0]   s_axis_tdata;
    logic [SW-1:0]   s_axis_tstrb;
    logic [UW-1:0]   s_axis_tuser;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [2*DW-1:0] m_axis_tdata;
    logic [2*SW-1:0] m_axis_tstrb;
    logic [2*UW-1:0] m_axis_tuser;
    logic [1:0]      m_axis_tvalid;
    logic [1:0]      m_axis_tready;
    logic [1:0]      m_axis_tlast;
    logic [1:0]      out_enable;
    logic [15:0]     dst_ports;
    logic [63:0]     pkt_count;
    logic [63:0]     drop_count;

    packet_replicator dut (
        .axi_aclk      (axi_aclk),
        .axi_aresetn   (axi_aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .out_enable    (out_enable),
        .dst_ports     (dst_ports),
        .pkt_count     (pkt_count),
        .drop_count    (drop_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    typedef struct packed {
        logic [31:0]   d;
        logic [UW-1:0] u;
        logic [SW-1:0] s;
        logic          l;
    } beat_t;

    typedef struct {
        logic [1:0]  en;
        logic [15:0] dst;
        int          n;
        logic [1:0]  deliver;
        logic [31:0] pk0;
        logic [31:0] pk1;
        logic [31:0] dr0;
        logic [31:0] dr1;
    } vec_t;

    beat_t q0[$];
    beat_t q1[$];
    int    compared   = 0;
    int    mismatched = 0;
    int    stalls     = 0;
    int    cycle      = 0;

    always @(posedge axi_aclk) cycle <= cycle + 1;

    function automatic beat_t grab(input int port);
        beat_t b;
        b.d = m_axis_tdata[port*DW +: 32];
        b.u = m_axis_tuser[port*UW +: UW];
        b.s = m_axis_tstrb[port*SW +: SW];
        b.l = m_axis_tlast[port];
        return b;
    endfunction

    // Output monitor: record each beat that will pop on the coming rising edge.
    always @(negedge axi_aclk) begin
        if (axi_aresetn && m_axis_tvalid[0] && m_axis_tready[0]) q0.push_back(grab(0));
        if (axi_aresetn && m_axis_tvalid[1] && m_axis_tready[1]) q1.push_back(grab(1));
    end

    function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [UW-1:0] user_in(input int p, input int b);
        logic [UW-1:0] u;
        u = {UW{1'b0}};
        u[127:96] = 32'hC0DE_0000 | 32'(p);
        u[31:24]  = (b == 0) ? 8'h04 : 8'hEE;
        u[23:16]  = 8'hA5;
        u[15:8]   = p[7:0];
        u[7:0]    = b[7:0];
        return u;
    endfunction

    function automatic beat_t exp_beat(input int p, input int b, input int n, input logic [7:0] dst);
        beat_t e;
        e.d = {p[15:0], b[15:0]};
        e.u = user_in(p, b);
        if (b == 0) e.u[31:24] = dst;
        e.s = (b == n - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        e.l = (b == n - 1);
        return e;
    endfunction

    task automatic send_beat(input int p, input int b, input int n, output int cyc);
        logic [31:0] d;
        int w;
        d = {p[15:0], b[15:0]};
        @(negedge axi_aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {8{d}};
        s_axis_tuser  = user_in(p, b);
        s_axis_tstrb  = (b == n - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        s_axis_tlast  = (b == n - 1);
        #1;
        w = 0;
        while (!s_axis_tready && w < 1000) begin
            @(negedge axi_aclk);
            #1;
            w++;
        end
        stalls += w;
        if (w >= 1000) begin
            $display("FAIL tready_timeout: got 0, expected 1");
            $fatal(1, "input never became ready");
        end
        @(posedge axi_aclk);
        #1;
        cyc = cycle;
    endtask

    task automatic send_pkt(input int p, input int n, output int c_first, output int c_last);
        int c;
        c_first = 0;
        c_last  = 0;
        for (int b = 0; b < n; b++) begin
            send_beat(p, b, n, c);
            if (b == 0) c_first = c;
            c_last = c;
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (m_axis_tvalid != 2'b00 && w < 2000) begin
            @(negedge axi_aclk);
            w++;
        end
        chk("drain_done", 256'(m_axis_tvalid), 256'(0));
    endtask

    task automatic check_pkt(input int port, input int p, input int n, input logic [7:0] dst);
        beat_t a;
        for (int b = 0; b < n; b++) begin
            if ((port == 0 && q0.size() == 0) || (port == 1 && q1.size() == 0)) begin
                compared++;
                mismatched++;
                $display("FAIL port%0d_pkt%0d_beat%0d: got no beat, expected one", port, p, b);
            end else begin
                if (port == 0) a = q0.pop_front();
                else           a = q1.pop_front();
                chk($sformatf("port%0d_pkt%0d_beat%0d", port, p, b), 256'(a), 256'(exp_beat(p, b, n, dst)));
            end
        end
    endtask

    task automatic check_counts(input string tag, input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] d0, input logic [31:0] d1);
        chk({tag, "_pkt_count"},  256'(pkt_count),  256'({p1, p0}));
        chk({tag, "_drop_count"}, 256'(drop_count), 256'({d1, d0}));
    endtask

    vec_t vecs[5];
    int   pid;
    int   cf, cl, cf2, cl2, c;
    int   k;

    initial begin
        vecs[0] = '{2'b11, 16'h8001, 4, 2'b11, 32'd1, 32'd1, 32'd0, 32'd0};
        vecs[1] = '{2'b01, 16'h3322, 3, 2'b01, 32'd2, 32'd1, 32'd0, 32'd0};
        vecs[2] = '{2'b10, 16'h5544, 1, 2'b10, 32'd2, 32'd2, 32'd0, 32'd0};
        vecs[3] = '{2'b00, 16'h7766, 3, 2'b00, 32'd2, 32'd2, 32'd0, 32'd0};
        vecs[4] = '{2'b11, 16'h00FF, 2, 2'b11, 32'd3, 32'd3, 32'd0, 32'd0};

        axi_aresetn   = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = {DW{1'b0}};
        s_axis_tstrb  = {SW{1'b0}};
        s_axis_tuser  = {UW{1'b0}};
        s_axis_tlast  = 1'b0;
        m_axis_tready = 2'b11;
        out_enable    = 2'b11;
        dst_ports     = 16'h8001;
        pid           = 1;

        // Reset state.
        #12;
        chk("reset_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("reset_tready", 256'(s_axis_tready), 256'(0));
        check_counts("reset", 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;

        // Table-driven single packets.
        for (int v = 0; v < 5; v++) begin
            out_enable = vecs[v].en;
            dst_ports  = vecs[v].dst;
            stalls     = 0;
            send_pkt(pid, vecs[v].n, cf, cl);
            wait_drain();
            for (int port = 0; port < 2; port++) begin
                if (vecs[v].deliver[port]) check_pkt(port, pid, vecs[v].n, vecs[v].dst[port*8 +: 8]);
            end
            chk($sformatf("vec%0d_q0_empty", v), 256'(q0.size()), 256'(0));
            chk($sformatf("vec%0d_q1_empty", v), 256'(q1.size()), 256'(0));
            check_counts($sformatf("vec%0d", v), vecs[v].pk0, vecs[v].pk1, vecs[v].dr0, vecs[v].dr1);
            if (v > 0) chk($sformatf("vec%0d_no_stall", v), 256'(stalls), 256'(0));
            pid++;
        end

        // First beat visible on both outputs one cycle after acceptance.
        out_enable = 2'b11;
        dst_ports  = 16'h8001;
        send_pkt(pid, 1, cf, cl);
        chk("latency_tvalid", 256'(m_axis_tvalid), 256'(2'b11));
        chk("latency_data0", 256'(m_axis_tdata[31:0]), 256'({pid[15:0], 16'h0000}));
        chk("latency_data1", 256'(m_axis_tdata[DW +: 32]), 256'({pid[15:0], 16'h0000}));
        wait_drain();
        check_pkt(0, pid, 1, 8'h01);
        check_pkt(1, pid, 1, 8'h80);
        pid++;

        // Single-beat packet then a 2-beat packet, back to back.
        stalls = 0;
        send_pkt(pid, 1, cf, cl);
        send_pkt(pid + 1, 2, cf2, cl2);
        chk("b2b_no_bubble", 256'(cl2 - cf), 256'(2));
        chk("b2b_no_stall", 256'(stalls), 256'(0));
        wait_drain();
        check_pkt(0, pid, 1, 8'h01);
        check_pkt(0, pid + 1, 2, 8'h01);
        check_pkt(1, pid, 1, 8'h80);
        check_pkt(1, pid + 1, 2, 8'h80);
        check_counts("b2b", 32'd6, 32'd6, 32'd0, 32'd0);
        pid += 2;

        // Configuration change mid-packet only affects the next packet.
        send_beat(pid, 0, 4, c);
        out_enable = 2'b01;
        dst_ports  = 16'h3377;
        for (int b = 1; b < 4; b++) send_beat(pid, b, 4, c);
        s_axis_tvalid = 1'b0;
        send_pkt(pid + 1, 2, cf, cl);
        wait_drain();
        check_pkt(0, pid, 4, 8'h01);
        check_pkt(1, pid, 4, 8'h80);
        check_pkt(0, pid + 1, 2, 8'h77);
        chk("toggle_q1_empty", 256'(q1.size()), 256'(0));
        check_counts("toggle", 32'd8, 32'd7, 32'd0, 32'd0);
        pid += 2;

        // Port 1 stalled: ten max-size packets, port 1 admits two then drops.
        out_enable    = 2'b11;
        dst_ports     = 16'h8001;
        m_axis_tready = 2'b01;
        stalls        = 0;
        for (int i = 0; i < 10; i++) send_pkt(pid + i, 50, cf, cl);
        chk("burst_no_stall", 256'(stalls), 256'(0));
        k = 0;
        while (m_axis_tvalid[0] && k < 2000) begin
            @(negedge axi_aclk);
            k++;
        end
        chk("burst_port0_drained", 256'(m_axis_tvalid[0]), 256'(0));
        for (int i = 0; i < 10; i++) check_pkt(0, pid + i, 50, 8'h01);
        check_counts("burst", 32'd18, 32'd9, 32'd0, 32'd8);
        @(posedge axi_aclk);
        #1;
        m_axis_tready = 2'b11;
        wait_drain();
        check_pkt(1, pid, 50, 8'h80);
        check_pkt(1, pid + 1, 50, 8'h80);
        chk("burst_q1_empty", 256'(q1.size()), 256'(0));
        pid += 10;

        // Asynchronous reset in the middle of a packet.
        m_axis_tready = 2'b00;
        k = $urandom_range(4, 1);
        for (int b = 0; b < k; b++) send_beat(pid, b, 6, c);
        chk("prereset_tvalid", 256'(m_axis_tvalid), 256'(2'b11));
        #2;
        axi_aresetn   = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        chk("midreset_tvalid", 256'(m_axis_tvalid), 256'(0));
        chk("midreset_tready", 256'(s_axis_tready), 256'(0));
        check_counts("midreset", 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge axi_aclk);
        axi_aresetn   = 1'b1;
        m_axis_tready = 2'b11;
        pid++;
        send_pkt(pid, 3, cf, cl);
        wait_drain();
        check_pkt(0, pid, 3, 8'h01);
        check_pkt(1, pid, 3, 8'h80);
        chk("postreset_q0_empty", 256'(q0.size()), 256'(0));
        chk("postreset_q1_empty", 256'(q1.size()), 256'(0));
        check_counts("postreset", 32'd1, 32'd1, 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
